// File: rtl/arc4_encrypt.sv
// ARC4 encryption engine: S-box init, key scheduling over a 3-byte key, then
// keystream generation that turns length-prefixed plaintext into ciphertext.
module arc4_encrypt (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    output logic        o_rdy,
    input  logic [23:0] i_key,
    output logic [7:0]  o_pt_addr,
    input  logic [7:0]  i_pt_rddata,
    output logic [7:0]  o_ct_addr,
    output logic [7:0]  o_ct_wrdata,
    output logic        o_ct_wren
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_KSA_RD,
        S_KSA_CALC,
        S_KSA_SW1,
        S_KSA_SW2,
        S_LEN_ADDR,
        S_LEN_DATA,
        S_PRGA_RD,
        S_PRGA_CALC,
        S_PRGA_SW1,
        S_PRGA_SW2,
        S_PRGA_PAD,
        S_PRGA_WR,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [23:0] r_key;
    logic [7:0]  r_i;
    logic [7:0]  r_j;
    logic [7:0]  r_si;
    logic [7:0]  r_sj;
    logic [7:0]  r_len;
    logic [8:0]  r_k;
    logic [1:0]  r_keyIdx;
    logic        r_rdy;
    logic [7:0]  r_ptAddr;
    logic [7:0]  r_ctAddr;
    logic [7:0]  r_ctWrdata;
    logic        r_ctWren;

    logic [7:0]  r_sMem [256];
    logic [7:0]  r_sQ;

    logic        w_sWe;
    logic [7:0]  w_sWa;
    logic [7:0]  w_sWd;
    logic [7:0]  w_sRa;
    logic [7:0]  w_keyByte;
    logic [7:0]  w_jKsa;
    logic [7:0]  w_jPrga;

    assign o_rdy       = r_rdy;
    assign o_pt_addr   = r_ptAddr;
    assign o_ct_addr   = r_ctAddr;
    assign o_ct_wrdata = r_ctWrdata;
    assign o_ct_wren   = r_ctWren;

    always_comb begin
        case (r_keyIdx)
            2'd0:    w_keyByte = r_key[23:16];
            2'd1:    w_keyByte = r_key[15:8];
            default: w_keyByte = r_key[7:0];
        endcase
    end

    assign w_jKsa  = r_j + r_sQ + w_keyByte;
    assign w_jPrga = r_j + r_sQ;

    // Every step is its own state, so a read is always issued after any
    // preceding write has landed; this removes the read-after-write hazard.
    always_comb begin
        w_sWe = 1'b0;
        w_sWa = r_i;
        w_sWd = r_i;
        w_sRa = r_i;
        case (r_state)
            S_INIT: begin
                w_sWe = 1'b1;
                w_sWa = r_i;
                w_sWd = r_i;
            end
            S_KSA_RD:    w_sRa = r_i;
            S_KSA_CALC:  w_sRa = w_jKsa;
            S_KSA_SW1: begin
                w_sWe = 1'b1;
                w_sWa = r_i;
                w_sWd = r_sQ;
            end
            S_KSA_SW2: begin
                w_sWe = 1'b1;
                w_sWa = r_j;
                w_sWd = r_si;
            end
            S_PRGA_RD:   w_sRa = r_i + 8'd1;
            S_PRGA_CALC: w_sRa = w_jPrga;
            S_PRGA_SW1: begin
                w_sWe = 1'b1;
                w_sWa = r_i;
                w_sWd = r_sQ;
            end
            S_PRGA_SW2: begin
                w_sWe = 1'b1;
                w_sWa = r_j;
                w_sWd = r_si;
            end
            S_PRGA_PAD:  w_sRa = r_si + r_sj;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_sWe) begin
            r_sMem[w_sWa] <= w_sWd;
        end
        r_sQ <= r_sMem[w_sRa];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_key      <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_si       <= '0;
            r_sj       <= '0;
            r_len      <= '0;
            r_k        <= '0;
            r_keyIdx   <= '0;
            r_rdy      <= 1'b1;
            r_ptAddr   <= '0;
            r_ctAddr   <= '0;
            r_ctWrdata <= '0;
            r_ctWren   <= 1'b0;
        end else begin
            r_ctWren <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_en) begin
                        r_key   <= i_key;
                        r_i     <= '0;
                        r_rdy   <= 1'b0;
                        r_state <= S_INIT;
                    end
                end
                S_INIT: begin
                    r_i <= r_i + 8'd1;
                    if (r_i == 8'hFF) begin
                        r_j      <= '0;
                        r_keyIdx <= '0;
                        r_state  <= S_KSA_RD;
                    end
                end
                S_KSA_RD:   r_state <= S_KSA_CALC;
                S_KSA_CALC: begin
                    r_si    <= r_sQ;
                    r_j     <= w_jKsa;
                    r_state <= S_KSA_SW1;
                end
                S_KSA_SW1:  r_state <= S_KSA_SW2;
                S_KSA_SW2: begin
                    r_i      <= r_i + 8'd1;
                    r_keyIdx <= (r_keyIdx == 2'd2) ? 2'd0 : r_keyIdx + 2'd1;
                    if (r_i == 8'hFF) begin
                        r_ptAddr <= '0;
                        r_state  <= S_LEN_ADDR;
                    end else begin
                        r_state <= S_KSA_RD;
                    end
                end
                S_LEN_ADDR: r_state <= S_LEN_DATA;
                S_LEN_DATA: begin
                    r_len      <= i_pt_rddata;
                    r_ctAddr   <= '0;
                    r_ctWrdata <= i_pt_rddata;
                    r_ctWren   <= 1'b1;
                    r_i        <= '0;
                    r_j        <= '0;
                    r_k        <= 9'd1;
                    r_state    <= (i_pt_rddata == 8'd0) ? S_DONE : S_PRGA_RD;
                end
                S_PRGA_RD: begin
                    r_i      <= r_i + 8'd1;
                    r_ptAddr <= r_k[7:0];
                    r_state  <= S_PRGA_CALC;
                end
                S_PRGA_CALC: begin
                    r_si    <= r_sQ;
                    r_j     <= w_jPrga;
                    r_state <= S_PRGA_SW1;
                end
                S_PRGA_SW1: begin
                    r_sj    <= r_sQ;
                    r_state <= S_PRGA_SW2;
                end
                S_PRGA_SW2: r_state <= S_PRGA_PAD;
                S_PRGA_PAD: r_state <= S_PRGA_WR;
                S_PRGA_WR: begin
                    r_ctAddr   <= r_k[7:0];
                    r_ctWrdata <= i_pt_rddata ^ r_sQ;
                    r_ctWren   <= 1'b1;
                    // Nine-bit counter lets a 255-byte message stop cleanly.
                    if (r_k == {1'b0, r_len}) begin
                        r_state <= S_DONE;
                    end else begin
                        r_k     <= r_k + 9'd1;
                        r_state <= S_PRGA_RD;
                    end
                end
                S_DONE: begin
                    r_rdy   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Self-checking bench for arc4_encrypt: external pt/ct memory models and a
// plain RC4 reference model computed directly from the algorithm.
module tb_arc4_encrypt;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [7:0]  ptAddr;
    logic [7:0]  ptData;
    logic [7:0]  ctAddr;
    logic [7:0]  ctWrdata;
    logic        ctWren;

    logic [7:0]  ptMem   [256];
    logic [7:0]  ctMem   [256];
    logic [7:0]  expCt   [256];
    logic [7:0]  origPt  [256];
    logic [7:0]  stdCt   [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8,
                                  8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0]  ptAddrS;
    logic [7:0]  prevPtAddr;

    int checks   = 0;
    int failures = 0;
    int wrCount  = 0;
    int addrErr  = 0;
    int holdErr  = 0;

    always #5 clk = ~clk;

    arc4_encrypt dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .o_rdy       (rdy),
        .i_key       (key),
        .o_pt_addr   (ptAddr),
        .i_pt_rddata (ptData),
        .o_ct_addr   (ctAddr),
        .o_ct_wrdata (ctWrdata),
        .o_ct_wren   (ctWren)
    );

    // Ct memory write port plus write-order and pt address hold monitoring.
    always @(negedge clk) begin
        if (ctWren === 1'b1) begin
            ctMem[ctAddr] = ctWrdata;
            if (32'(ctAddr) != 32'(wrCount)) addrErr++;
            if (ptAddr !== ctAddr || prevPtAddr !== ctAddr) holdErr++;
            wrCount++;
        end
        prevPtAddr = ptAddr;
        ptAddrS    = ptAddr;
    end

    // Pt memory with one cycle of read latency.
    always @(posedge clk) begin
        ptData <= ptMem[ptAddrS];
    end

    function automatic void computeModel(input logic [23:0] k);
        int s [256];
        int i, j, t, len;
        for (int n = 0; n < 256; n++) s[n] = n;
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + s[n] + int'((k >> (8 * (2 - n % 3))) & 24'hFF)) % 256;
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        len      = int'(ptMem[0]);
        expCt[0] = ptMem[0];
        i = 0;
        j = 0;
        for (int n = 1; n <= len; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            expCt[n] = ptMem[n] ^ 8'(s[(s[i] + s[j]) % 256]);
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [23:0] k, output int cycles);
        wrCount = 0;
        addrErr = 0;
        holdErr = 0;
        @(negedge clk);
        key = k;
        en  = 1'b1;
        @(negedge clk);
        en = 1'b0;
        checkOutput("rdy_drop", 32'(rdy), 32'd0);
        cycles = 1;
        while (rdy !== 1'b1 && cycles < 6000) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic checkJob(input string name, input int len, input int cycles);
        checkOutput({name, "_in_budget"},
                    32'((cycles <= 256 + 1536 + 3 + 8 * len + 2) ? 1 : 0), 32'd1);
        checkOutput({name, "_nwrites"}, 32'(wrCount), 32'(len + 1));
        checkOutput({name, "_addr_order"}, 32'(addrErr), 32'd0);
        checkOutput({name, "_pt_hold"}, 32'(holdErr), 32'd0);
        for (int n = 0; n <= len; n++) begin
            checkOutput($sformatf("%s_ct%0d", name, n), 32'(ctMem[n]), 32'(expCt[n]));
        end
    endtask

    task automatic loadStandardPt();
        string s = "Plaintext";
        ptMem[0] = 8'd9;
        for (int n = 0; n < 9; n++) ptMem[n + 1] = s[n];
    endtask

    task automatic checkStandard(input string name, input int cycles);
        checkOutput({name, "_in_budget"},
                    32'((cycles <= 256 + 1536 + 3 + 72 + 2) ? 1 : 0), 32'd1);
        checkOutput({name, "_nwrites"}, 32'(wrCount), 32'd10);
        checkOutput({name, "_rdy_back"}, 32'(rdy), 32'd1);
        for (int n = 0; n < 10; n++) begin
            checkOutput($sformatf("%s_ct%0d", name, n), 32'(ctMem[n]), 32'(stdCt[n]));
        end
    endtask

    initial begin
        int          cycles;
        int          len;
        logic [23:0] k1;
        logic [23:0] k2;

        rst = 1'b1;
        en  = 1'b0;
        key = '0;
        for (int n = 0; n < 256; n++) begin
            ptMem[n] = 8'h00;
            ctMem[n] = 8'h00;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_rdy", 32'(rdy), 32'd1);
        checkOutput("reset_wren", 32'(ctWren), 32'd0);
        checkOutput("reset_ct_addr", 32'(ctAddr), 32'd0);
        checkOutput("reset_ct_wrdata", 32'(ctWrdata), 32'd0);
        checkOutput("reset_pt_addr", 32'(ptAddr), 32'd0);

        $display("[TB] standard vector");
        loadStandardPt();
        applyStimulus(24'h4B6579, cycles);
        checkStandard("std", cycles);
        checkOutput("std_addr_order", 32'(addrErr), 32'd0);
        checkOutput("std_pt_hold", 32'(holdErr), 32'd0);

        $display("[TB] zero length");
        ptMem[0] = 8'h00;
        ctMem[0] = 8'h77;
        ctMem[1] = 8'hA5;
        applyStimulus(24'($urandom), cycles);
        checkOutput("zero_nwrites", 32'(wrCount), 32'd1);
        checkOutput("zero_ct0", 32'(ctMem[0]), 32'd0);
        checkOutput("zero_ct1_untouched", 32'(ctMem[1]), 32'hA5);
        checkOutput("zero_rdy_back", 32'(rdy), 32'd1);

        $display("[TB] random jobs");
        for (int r = 0; r < 4; r++) begin
            k1  = 24'($urandom);
            len = int'($urandom_range(1, 40));
            ptMem[0] = 8'(len);
            for (int n = 1; n <= len; n++) ptMem[n] = 8'($urandom);
            computeModel(k1);
            applyStimulus(k1, cycles);
            checkJob($sformatf("rand%0d", r), len, cycles);
        end

        $display("[TB] round trip");
        ptMem[0] = 8'hFF;
        for (int n = 1; n < 256; n++) begin
            ptMem[n]  = 8'($urandom_range(32, 126));
            origPt[n] = ptMem[n];
        end
        computeModel(24'h000018);
        applyStimulus(24'h000018, cycles);
        checkJob("rt_enc", 255, cycles);
        for (int n = 0; n < 256; n++) ptMem[n] = ctMem[n];
        applyStimulus(24'h000018, cycles);
        checkOutput("rt_dec_nwrites", 32'(wrCount), 32'd256);
        checkOutput("rt_dec_len", 32'(ctMem[0]), 32'hFF);
        for (int n = 1; n < 256; n++) begin
            checkOutput($sformatf("rt_dec_pt%0d", n), 32'(ctMem[n]), 32'(origPt[n]));
        end

        $display("[TB] reset during key scheduling");
        loadStandardPt();
        wrCount = 0;
        @(negedge clk);
        key = 24'h123456;
        en  = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (400) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_rdy", 32'(rdy), 32'd1);
        repeat (20) @(negedge clk);
        checkOutput("midrst_no_wren", 32'(wrCount), 32'd0);
        checkOutput("midrst_still_idle", 32'(rdy), 32'd1);
        applyStimulus(24'h4B6579, cycles);
        checkStandard("after_rst", cycles);

        $display("[TB] back to back with key change");
        k1 = 24'h4B6579;
        k2 = 24'($urandom) | 24'h000001;
        if (k2 == k1) k2 = k1 ^ 24'h010101;
        wrCount = 0;
        @(negedge clk);
        key = k1;
        en  = 1'b1;
        repeat (100) @(negedge clk);
        key = k2;
        cycles = 0;
        while (rdy !== 1'b1 && cycles < 6000) begin
            @(negedge clk);
            cycles++;
        end
        checkStandard("b2b_first", cycles);
        wrCount = 0;
        addrErr = 0;
        holdErr = 0;
        @(negedge clk);
        checkOutput("b2b_one_rdy_cycle", 32'(rdy), 32'd0);
        en = 1'b0;
        computeModel(k2);
        cycles = 1;
        while (rdy !== 1'b1 && cycles < 6000) begin
            @(negedge clk);
            cycles++;
        end
        checkJob("b2b_second", 9, cycles);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
